cdic_host_if: RTL and testbench
===============================

Name: cdic_host_if

Overview:
- Host-side register and buffer interface of the CD interface controller (CDIC), selected by the 68070 bus decoder for the 0x30xxxx window.
- Provides a 16-bit, byte-lane-writable buffer RAM and a small control/status register file.
- Read data is combinational, so the CPU can complete a cycle with an always-asserted acknowledge.
- The block owns no bus acknowledge output.

Parameters:
RAM_WORDS, 7680, number of 16-bit buffer RAM words (offsets 0x0000-0x3BFF).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
resetn  input  1  asynchronous active-low reset.
address  input  23  CPU word address [23:1]; only [13:1] is decoded, so the window mirrors every 16 KB.
din  input  16  CPU write data.
dout  output  16  read data, combinational.
uds  input  1  upper byte strobe (lane [15:8]), active high.
lds  input  1  lower byte strobe (lane [7:0]), active high.
write_strobe  input  1  1 = write cycle, 0 = read cycle.
cs  input  1  chip select from the external decoder, active high.

Behaviour:
- Access qualifier: acc = cs && (uds || lds). Define rd = acc && !write_strobe and wr = acc && write_strobe. Let off = {address[13:1], 1'b0}.
- Address map by off:
  - 0x0000-0x3BFF: buffer RAM. Word index = address[13:1].
  - 0x3C00 CMD.
  - 0x3C02 TIMEHI.
  - 0x3C04 TIMELO.
  - 0x3C06 FILE (bits [7:0] only; [15:8] read 0).
  - 0x3C08 CHANHI.
  - 0x3C0A CHANLO.
  - 0x3C0C ACHAN.
  - 0x3FF4 ABUF.
  - 0x3FF6 XBUF.
  - 0x3FF8 DMACTL.
  - 0x3FFA AUDCTL.
  - 0x3FFC IVEC.
  - 0x3FFE DBUF.
  - Every other offset is unmapped: reads return 0x0000 and writes are ignored.
- Writes: on each rising clk with wr, write din[15:8] if uds and din[7:0] if lds into the addressed RAM word or register.
  - A multi-cycle bus write rewrites the same value, which is harmless.
  - Unstrobed byte lanes are preserved.
- Reads: dout = addressed content while cs is high, whatever the strobe state; dout = 0x0000 when cs is low.
  - RAM reads are asynchronous.
  - Strobes do not mask dout; the CPU selects the lane.
- Read-clear status (ABUF, XBUF): bit 15 is the "buffer ready" flag.
  - On the first cycle of a rd to ABUF or XBUF, record a pending-clear for that register.
  - When that access ends (acc falls), clear bit 15 of the register.
  - dout therefore stays stable for the whole bus cycle, and exactly one clear happens per access.
  - A write to bit 15 of ABUF or XBUF in the same cycle as the clear wins over the clear.
- AUDCTL: bit 11 reads back as the written value. All other bits are plain R/W.
- DBUF: plain R/W. Bits [2:0] select the active data buffer; the upper bits are reserved but stored.
- CMD, TIME, CHAN, ACHAN, DMACTL, IVEC: plain 16-bit R/W.
- Reset (resetn low, asynchronous):
  - All registers cleared to 0x0000.
  - Pending-clear flags cleared.
  - RAM contents unaffected, undefined after power-up.
  - dout follows its combinational rule (0x0000 if cs is low).
  - Reset asserted mid-access aborts any pending clear.
- Simultaneous events:
  - A write and a read cannot overlap (single bus master).
  - Mirror addresses behave identically, e.g. 0x307C00 aliases 0x303C00.
- Implementation target: RAM plus register file plus decode and read-clear logic, 120-400 lines.

Test Plan:
1. Reset, then cs=1 read at 0x303C00 and 0x303FFC -> dout=0x0000 for both; with cs=0, dout=0x0000.
2. Byte-lane write: write 0x1234 with uds=lds=1 to RAM offset 0x0010; write 0xAB00 with uds only; read back -> 0xAB34. Write 0x00CD with lds only -> 0xABCD.
3. Register R/W: write 0x5A5A to IVEC (0x303FFC) -> reads 0x5A5A. Write 0xFFFF to FILE -> reads 0x00FF. Read unmapped 0x303D00 -> 0x0000.
4. Read-clear: write 0x8003 to ABUF; hold a 3-cycle read -> dout=0x8003 on every cycle; after acc falls, next read -> 0x0003. XBUF behaves the same.
5. Mirroring: write 0xBEEF to 0x303C02; read 0x307C02 and 0x30FC02 -> 0xBEEF.
6. Async reset mid-access: during a held ABUF read with value 0x8001, pulse resetn low between clock edges -> register reads 0x0000 immediately; after release no spurious clear; RAM word written in test 2 still reads 0xABCD.

Source files
------------

// File: rtl/cdic_host_if.sv
// cdic_host_if: CDIC host-side buffer RAM and control/status register file
// with byte-lane writes, combinational read data and read-clear ABUF/XBUF flags.
module cdic_host_if #(
    parameter int RAM_WORDS = 7680
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:1] address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic        cs
);
    localparam logic [3:0] R_FILE = 4'd3;
    localparam logic [3:0] R_ABUF = 4'd7;
    localparam logic [3:0] R_XBUF = 4'd8;

    logic [15:0] ram_q [RAM_WORDS];
    logic [15:0] regs_q [13];
    logic [15:0] regs_d [13];
    logic [1:0]  pend_q, pend_d;
    logic [12:0] a;
    logic        acc, rd, wr, is_ram, lo_hit, hi_hit, is_reg;
    logic [3:0]  ri;
    logic        unused_addr;

    assign a           = address[13:1];
    assign unused_addr = ^address[23:14];
    assign acc         = cs && (uds || lds);
    assign rd          = acc && !write_strobe;
    assign wr          = acc && write_strobe;
    assign is_ram      = {19'd0, a} < RAM_WORDS;
    // 0x3C00..0x3C0C map to slots 0..6, 0x3FF4..0x3FFE to slots 7..12
    assign lo_hit      = a[12:3] == 10'h3C0 && a[2:0] != 3'd7;
    assign hi_hit      = a[12:3] == 10'h3FF && a[2:0] >= 3'd2;
    assign is_reg      = lo_hit || hi_hit;
    assign ri          = lo_hit ? {1'b0, a[2:0]} : {1'b0, a[2:0]} + 4'd5;

    always_ff @(posedge clk) begin
        if (wr && is_ram) begin
            if (uds) ram_q[a][15:8] <= din[15:8];
            if (lds) ram_q[a][7:0]  <= din[7:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 13; i++) regs_d[i] = regs_q[i];
        pend_d = pend_q;
        if (!acc) begin
            if (pend_q[0]) regs_d[R_ABUF][15] = 1'b0;
            if (pend_q[1]) regs_d[R_XBUF][15] = 1'b0;
            pend_d = 2'b00;
        end else if (rd && hi_hit) begin
            if (ri == R_ABUF) pend_d[0] = 1'b1;
            if (ri == R_XBUF) pend_d[1] = 1'b1;
        end
        if (wr && is_reg) begin
            if (uds) regs_d[ri][15:8] = (ri == R_FILE) ? 8'h00 : din[15:8];
            if (lds) regs_d[ri][7:0]  = din[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 13; i++) regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < 13; i++) regs_q[i] <= regs_d[i];
            pend_q <= pend_d;
        end
    end

    always_comb begin
        dout = 16'h0000;
        if (cs) dout = is_ram ? ram_q[a] : is_reg ? regs_q[ri] : 16'h0000;
    end
endmodule

// File: tb/tb_cdic_host_if.sv
// tb_cdic_host_if: directed vector table plus hand sequences for read-clear and async reset.
module tb_cdic_host_if;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:1] address = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        uds = 1'b0;
    logic        lds = 1'b0;
    logic        write_strobe = 1'b0;
    logic        cs = 1'b0;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        string       name;
        logic [23:0] addr;
        logic [15:0] d;
        logic        u;
        logic        l;
        logic        we;
        logic        c;
        logic [15:0] exp;
    } vec_t;

    vec_t v[$];

    cdic_host_if dut (
        .clk(clk), .resetn(resetn), .address(address), .din(din), .dout(dout),
        .uds(uds), .lds(lds), .write_strobe(write_strobe), .cs(cs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %04h expected %04h", n, got, exp);
    endtask

    task automatic idle();
        cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    endtask

    task automatic drive(input logic [23:0] ad, input logic [15:0] d, input logic u,
                         input logic l, input logic we, input logic c);
        address = ad[23:1]; din = d; uds = u; lds = l; write_strobe = we; cs = c;
    endtask

    task automatic wr_cycle(input logic [23:0] ad, input logic [15:0] d, input logic u,
                            input logic l, input logic c);
        @(negedge clk);
        drive(ad, d, u, l, 1'b1, c);
        @(negedge clk);
        idle();
    endtask

    task automatic rd_check(input string n, input logic [23:0] ad, input logic u,
                            input logic l, input logic c, input logic [15:0] exp);
        @(negedge clk);
        drive(ad, 16'h0, u, l, 1'b0, c);
        #1 chk(n, dout, exp);
        @(negedge clk);
        idle();
    endtask

    task automatic held_read(input string n, input logic [23:0] ad, input logic [15:0] exp);
        @(negedge clk);
        drive(ad, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1 chk(n, dout, exp);
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        v.push_back('{"rst_cmd",      24'h303C00, 16'h0000, 1, 1, 0, 1, 16'h0000});
        v.push_back('{"rst_ivec",     24'h303FFC, 16'h0000, 1, 1, 0, 1, 16'h0000});
        v.push_back('{"cs_low",       24'h303C00, 16'h0000, 1, 1, 0, 0, 16'h0000});
        v.push_back('{"",             24'h300010, 16'h1234, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"",             24'h300010, 16'hAB00, 1, 0, 1, 1, 16'h0000});
        v.push_back('{"ram_uds",      24'h300010, 16'h0000, 1, 1, 0, 1, 16'hAB34});
        v.push_back('{"",             24'h300010, 16'h00CD, 0, 1, 1, 1, 16'h0000});
        v.push_back('{"ram_lds",      24'h300010, 16'h0000, 1, 1, 0, 1, 16'hABCD});
        v.push_back('{"",             24'h303BFE, 16'h7777, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"ram_last",     24'h303BFE, 16'h0000, 1, 1, 0, 1, 16'h7777});
        v.push_back('{"",             24'h303FFC, 16'h5A5A, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"ivec",         24'h303FFC, 16'h0000, 1, 1, 0, 1, 16'h5A5A});
        v.push_back('{"ivec_nostrb",  24'h303FFC, 16'h0000, 0, 0, 0, 1, 16'h5A5A});
        v.push_back('{"ivec_cs0",     24'h303FFC, 16'h0000, 1, 1, 0, 0, 16'h0000});
        v.push_back('{"",             24'h303FFC, 16'h0000, 1, 1, 1, 0, 16'h0000});
        v.push_back('{"ivec_wr_cs0",  24'h303FFC, 16'h0000, 1, 1, 0, 1, 16'h5A5A});
        v.push_back('{"",             24'h303C06, 16'hFFFF, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"file",         24'h303C06, 16'h0000, 1, 1, 0, 1, 16'h00FF});
        v.push_back('{"",             24'h303D00, 16'h1111, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"unmap_3d00",   24'h303D00, 16'h0000, 1, 1, 0, 1, 16'h0000});
        v.push_back('{"",             24'h303C0E, 16'h2222, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"unmap_3c0e",   24'h303C0E, 16'h0000, 1, 1, 0, 1, 16'h0000});
        v.push_back('{"",             24'h303FFA, 16'h0800, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"audctl",       24'h303FFA, 16'h0000, 1, 1, 0, 1, 16'h0800});
        v.push_back('{"",             24'h303FFE, 16'hFFF5, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"dbuf",         24'h303FFE, 16'h0000, 1, 1, 0, 1, 16'hFFF5});
        v.push_back('{"",             24'h303C02, 16'hBEEF, 1, 1, 1, 1, 16'h0000});
        v.push_back('{"mirror_7c02",  24'h307C02, 16'h0000, 1, 1, 0, 1, 16'hBEEF});
        v.push_back('{"mirror_fc02",  24'h30FC02, 16'h0000, 1, 1, 0, 1, 16'hBEEF});
        v.push_back('{"timelo",       24'h303C04, 16'h0000, 1, 1, 0, 1, 16'h0000});

        repeat (3) @(negedge clk);
        resetn = 1'b1;

        foreach (v[i]) begin
            if (v[i].we) wr_cycle(v[i].addr, v[i].d, v[i].u, v[i].l, v[i].c);
            else rd_check(v[i].name, v[i].addr, v[i].u, v[i].l, v[i].c, v[i].exp);
        end

        wr_cycle(24'h303FF4, 16'h8003, 1'b1, 1'b1, 1'b1);
        held_read("abuf_held", 24'h303FF4, 16'h8003);
        rd_check("abuf_cleared", 24'h303FF4, 1'b1, 1'b1, 1'b1, 16'h0003);
        wr_cycle(24'h303FF6, 16'h8005, 1'b1, 1'b1, 1'b1);
        held_read("xbuf_held", 24'h303FF6, 16'h8005);
        rd_check("xbuf_cleared", 24'h303FF6, 1'b1, 1'b1, 1'b1, 16'h0005);
        rd_check("abuf_intact", 24'h303FF4, 1'b1, 1'b1, 1'b1, 16'h0003);

        wr_cycle(24'h303FF4, 16'h8001, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(24'h303FF4, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("abuf_pre_rst", dout, 16'h8001);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk("abuf_async_rst", dout, 16'h0000);
        #1 resetn = 1'b1;
        @(negedge clk);
        drive(24'h303FF4, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        rd_check("abuf_no_spurious", 24'h303FF4, 1'b1, 1'b1, 1'b1, 16'h8001);
        rd_check("ivec_after_rst", 24'h303FFC, 1'b1, 1'b1, 1'b1, 16'h0000);
        rd_check("ram_after_rst", 24'h300010, 1'b1, 1'b1, 1'b1, 16'hABCD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
